// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback arbiter: address width,
// the buffered writeback request and the LSU buffer occupancy states.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  // Widest write-data path the request struct can carry; XLEN must not exceed it.
  localparam int WB_WD_MAX  = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_WD_MAX-1:0]  wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order buffer for long-latency writeback results, with a registered
// occupancy count and EMPTY/PARTIAL/FULL state.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head_req,
  output logic [CNT_W-1:0] count,
  output occ_state_t       state
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  occ_state_t       state_q, state_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (count_d == '0) begin
      state_d = OCC_EMPTY;
    end else if (count_d == CNT_W'(DEPTH)) begin
      state_d = OCC_FULL;
    end else begin
      state_d = OCC_PARTIAL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= OCC_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_req;
    end
  end

  assign head_req = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign state    = state_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU writebacks win unconditionally, LSU
// results queue in rf_wb_fifo. Optional x0 filtering via RF_WB_X0_FILTER_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_we,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_wd,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_wd,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]       wd3,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Low until the first edge after reset release, so release is taken synchronously.
  logic                  run_q, run_d;
  logic                  we3_q, we3_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [XLEN-1:0]       wd3_q, wd3_d;

  wb_req_t          push_req;
  wb_req_t          head_req;
  logic [CNT_W-1:0] fifo_count;
  occ_state_t       occ_state;
  logic             alu_grant;
  logic             lsu_xfer;
  logic             push;
  logic             pop;
  logic             unused_head_hi;

  assign lsu_ready = run_q && (fifo_count < CNT_W'(DEPTH));
  assign lsu_xfer  = lsu_valid && lsu_ready;

`ifdef RF_WB_X0_FILTER_EN
  assign alu_grant = run_q && alu_we && (alu_rd != '0);
  assign push      = lsu_xfer && (lsu_rd != '0);
`else
  assign alu_grant = run_q && alu_we;
  assign push      = lsu_xfer;
`endif

  assign pop            = !alu_grant && (occ_state != OCC_EMPTY);
  assign busy           = (occ_state != OCC_EMPTY);
  assign unused_head_hi = ^head_req.wd;

  always_comb begin
    push_req                = '0;
    push_req.rd             = lsu_rd;
    push_req.wd[XLEN-1:0]   = lsu_wd;
  end

  always_comb begin
    run_d = 1'b1;
    we3_d = alu_grant || pop;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (alu_grant) begin
      a3_d  = alu_rd;
      wd3_d = alu_wd;
    end else if (pop) begin
      a3_d  = head_req.rd;
      wd3_d = head_req.wd[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      run_q <= run_d;
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

  rf_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_req(push_req),
    .pop     (pop),
    .head_req(head_req),
    .count   (fifo_count),
    .state   (occ_state)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
`ifdef RF_WB_X0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            alu_we = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_wd = '0;
  logic            lsu_valid = 1'b0;
  logic            lsu_ready;
  logic [4:0]      lsu_rd = '0;
  logic [XLEN-1:0] lsu_wd = '0;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic            busy;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_we   (alu_we),
    .alu_rd   (alu_rd),
    .alu_wd   (alu_wd),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_rd   (lsu_rd),
    .lsu_wd   (lsu_wd),
    .we3      (we3),
    .a3       (a3),
    .wd3      (wd3),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending LSU results and the expected outputs.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } ent_t;

  ent_t            mq[$];
  bit              m_rdy = 1'b0;
  bit              m_we = 1'b0;
  logic [4:0]      m_a3 = '0;
  logic [XLEN-1:0] m_wd = '0;

  always @(negedge reset) begin
    mq.delete();
    m_rdy = 1'b0;
    m_we  = 1'b0;
    m_a3  = '0;
    m_wd  = '0;
  end

  always @(posedge clk) begin : cmp
    bit   ready;
    ent_t e;
    if (reset) begin
      ready = m_rdy && (mq.size() < DEPTH);
      if (m_rdy && alu_we && !(FILT && alu_rd == 5'd0)) begin
        m_we = 1'b1;
        m_a3 = alu_rd;
        m_wd = alu_wd;
      end else if (mq.size() > 0) begin
        e    = mq.pop_front();
        m_we = 1'b1;
        m_a3 = e.rd;
        m_wd = e.wd;
      end else begin
        m_we = 1'b0;
      end
      if (lsu_valid && ready && !(FILT && lsu_rd == 5'd0)) begin
        e.rd = lsu_rd;
        e.wd = lsu_wd;
        mq.push_back(e);
      end
      m_rdy = 1'b1;
      #1;
      if (reset) begin
        chk("model_we3", 32'(we3), 32'(m_we));
        chk("model_a3", 32'(a3), 32'(m_a3));
        chk("model_wd3", wd3, m_wd);
        chk("model_lsu_ready", 32'(lsu_ready), 32'(m_rdy && (mq.size() < DEPTH)));
        chk("model_busy", 32'(busy), 32'(mq.size() != 0));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);

    reset = 1'b1;
    cyc();
    chk("idle_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("idle_we3", 32'(we3), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    cyc();
    chk("alu_we3", 32'(we3), 32'd1);
    chk("alu_a3", 32'(a3), 32'd5);
    chk("alu_wd3", wd3, 32'hDEADBEEF);
    alu_we = 1'b0;
    cyc();
    chk("alu_idle_we3", 32'(we3), 32'd0);
    chk("alu_hold_a3", 32'(a3), 32'd5);
    chk("alu_hold_wd3", wd3, 32'hDEADBEEF);

    alu_we = 1'b1; alu_rd = 5'd1; alu_wd = 32'h100;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h11;
    cyc();
    lsu_rd = 5'd8; lsu_wd = 32'h22;
    cyc();
    lsu_valid = 1'b0;
    chk("stall_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    repeat (2) cyc();
    chk("stall_hold_busy", 32'(busy), 32'd1);
    alu_we = 1'b0;
    cyc();
    chk("drain1_we3", 32'(we3), 32'd1);
    chk("drain1_a3", 32'(a3), 32'd7);
    chk("drain1_wd3", wd3, 32'h11);
    cyc();
    chk("drain2_a3", 32'(a3), 32'd8);
    chk("drain2_wd3", wd3, 32'h22);
    chk("drain2_busy", 32'(busy), 32'd0);

    alu_we = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h33;
    cyc();
    lsu_rd = 5'd10; lsu_wd = 32'h44;
    cyc();
    chk("full_lsu_ready", 32'(lsu_ready), 32'd0);
    alu_we = 1'b0; lsu_rd = 5'd11; lsu_wd = 32'h55;
    cyc();
    chk("fullpop_a3", 32'(a3), 32'd9);
    chk("fullpop_lsu_ready", 32'(lsu_ready), 32'd1);
    cyc();
    chk("fullpop2_a3", 32'(a3), 32'd10);
    lsu_valid = 1'b0;
    cyc();
    chk("fullpop3_a3", 32'(a3), 32'd11);
    chk("fullpop3_wd3", wd3, 32'h55);
    cyc();
    chk("fullpop_end_we3", 32'(we3), 32'd0);
    chk("fullpop_end_busy", 32'(busy), 32'd0);

    alu_we = 1'b1; alu_rd = 5'd2; lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_wd = 32'h66;
    cyc();
    lsu_rd = 5'd13;
    cyc();
    lsu_valid = 1'b0;
    chk("prerst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_we3", 32'(we3), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_lsu_ready", 32'(lsu_ready), 32'd0);
    alu_we = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("postrst_we3", 32'(we3), 32'd0);
    end

`ifdef RF_WB_X0_FILTER_EN
    alu_we = 1'b1; alu_rd = 5'd3; lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_wd = 32'h77;
    cyc();
    lsu_valid = 1'b0; alu_rd = 5'd0;
    cyc();
    chk("x0_drain_we3", 32'(we3), 32'd1);
    chk("x0_drain_a3", 32'(a3), 32'd14);
    cyc();
    chk("x0_no_write", 32'(we3), 32'd0);
    alu_we = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      alu_we    = ($urandom_range(0, 99) < 40);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_wd    = $urandom;
      lsu_valid = ($urandom_range(0, 99) < 60);
      lsu_rd    = 5'($urandom_range(0, 31));
      lsu_wd    = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        cyc();
        reset = 1'b1;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, sets the data width of all write-data paths.
REQ-002 Parameter DEPTH, default 2, sets the number of LSU result buffer entries; legal values are 2 to 8.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 alu_we  input  1  single-cycle pipeline writeback request; has no backpressure.
REQ-006 alu_rd  input  5  destination register for the ALU request.
REQ-007 alu_wd  input  XLEN  write data for the ALU request.
REQ-008 lsu_valid  input  1  long-latency (load/mul-div) result valid.
REQ-009 lsu_ready  output  1  arbiter can accept an LSU result this cycle.
REQ-010 lsu_rd  input  5  destination register for the LSU result.
REQ-011 lsu_wd  input  XLEN  write data for the LSU result.
REQ-012 we3  output  1  register-file write enable.
REQ-013 a3  output  5  register-file write address.
REQ-014 wd3  output  XLEN  register-file write data.
REQ-015 busy  output  1  high while any LSU result is buffered.

Function
REQ-016 An LSU transfer SHALL occur on a rising edge where lsu_valid and lsu_ready are both high; lsu_rd and lsu_wd SHALL then be enqueued into a FIFO.
REQ-017 lsu_ready SHALL equal (count < DEPTH), based on registered state only; a same-cycle dequeue SHALL NOT raise lsu_ready when the FIFO is full.
REQ-018 we3, a3 and wd3 SHALL be registered, giving exactly 1 cycle of latency from a request being granted to its appearance on the outputs.
REQ-019 When alu_we=1, the ALU request SHALL be granted: the next cycle drives we3=1, a3=alu_rd and wd3=alu_wd, and no dequeue occurs.
REQ-020 When alu_we=0 and count>0, the FIFO head SHALL be dequeued and driven on the outputs the next cycle.
REQ-021 When alu_we=0 and count=0, we3 SHALL be 0 the next cycle; a3 and wd3 SHALL hold their previous values.
REQ-022 An LSU result SHALL never bypass the FIFO; an enqueue into an empty FIFO is eligible for grant no earlier than the following cycle.
REQ-023 FIFO results SHALL retire in arrival order.
REQ-024 The read and write pointers SHALL wrap modulo DEPTH; count SHALL be tracked as $clog2(DEPTH+1) bits.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-026 Occupancy state SHALL be EMPTY (count=0), PARTIAL or FULL (count=DEPTH); transitions follow count, and busy=(state!=EMPTY).
REQ-027 Continuous alu_we=1 SHALL hold the FIFO undrained indefinitely; busy and lsu_ready SHALL reflect this with no data loss.

Reset
REQ-028 While reset=0: we3=0, a3=0, wd3=0, count=0, both pointers=0, state=EMPTY, busy=0, lsu_ready=0.
REQ-029 Deassertion SHALL be synchronised; lsu_ready SHALL rise on the first rising edge after release.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries and any pending output write.

Configuration
REQ-031 The macro RF_WB_X0_FILTER_EN SHALL control x0-write filtering.
REQ-032 With RF_WB_X0_FILTER_EN defined: an ALU request with alu_rd=0 SHALL be treated as alu_we=0, so the FIFO may drain that cycle; an accepted LSU result with lsu_rd=0 SHALL be consumed and not enqueued.
REQ-033 Without RF_WB_X0_FILTER_EN: x0 requests SHALL be arbitrated and enqueued like any other request, and we3 is emitted for them.

Structure
REQ-034 A shared package rf_pkg SHALL hold the REG_ADDR_W=5 constant, the wb_req_t struct {rd, wd} and the occupancy-state enum.
REQ-035 The FIFO SHALL be implemented as sub-module rf_wb_fifo, instantiated once.

Verification
REQ-036 Reset then idle: we3=0, busy=0 and lsu_ready=1 one cycle after reset release.
REQ-037 ALU only, alu_rd=5, alu_wd=0xDEADBEEF: the next cycle shows we3=1, a3=5, wd3=0xDEADBEEF.
REQ-038 LSU rd=7/0x11 and rd=8/0x22 accepted back-to-back while alu_we=1 for 4 cycles: lsu_ready=0 after the second transfer; after alu_we drops, the outputs show rd 7 then rd 8 on consecutive cycles; busy then falls.
REQ-039 FIFO full with lsu_valid=1 and alu_we=0: a dequeue occurs and no enqueue happens that cycle; lsu_ready=1 on the next cycle.
REQ-040 Assert reset with 2 entries buffered: we3=0 and busy=0 immediately; no stale write appears after release.
REQ-041 With RF_WB_X0_FILTER_EN defined, alu_we=1 and alu_rd=0 while 1 entry is buffered: the entry drains the next cycle and no x0 write is emitted.
